// File: rtl/div_arb_pkg.sv
// Shared types and default sizing for the shared divider arbiter.
package div_arb_pkg;

  localparam int unsigned DIV_N    = 24;
  localparam int unsigned DIV_NREQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_core.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// The dividend shifts out of the top of dq_q while quotient bits shift in at
// the bottom, so one register serves both. quotient/remainder/done present
// the result of the step being taken this cycle, so the final values are
// available in the same cycle that done is high.
module div_core
  import div_arb_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         abort,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  rem_q;
  logic [N-1:0]  dq_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          ge;

  // One restoring step; the borrow out of the N+1-bit subtract is the compare.
  always_comb begin
    shifted   = {rem_q, dq_q[N-1]};
    diff      = shifted - {1'b0, dvs_q};
    ge        = ~diff[N];
    quotient  = {dq_q[N-2:0], ge};
    remainder = ge ? diff[N-1:0] : shifted[N-1:0];
    done      = active_q && (cnt_q == CW'(N - 1));
  end

  // Operand load on start, then N steps; abort drops the operation.
  always_ff @(posedge clk) begin
    if (abort) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      rem_q    <= '0;
      dq_q     <= dividend;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= remainder;
      dq_q  <= quotient;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one div_core among NREQ requesters.
// Results return a fixed N+1 cycles after the handshake, tagged with the
// requester index.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N    = DIV_N,
  parameter int unsigned NREQ = DIV_NREQ,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              pixelclk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_quotient,
  output logic [N-1:0]      rsp_remainder,
  output logic              rsp_div0,
  output logic              busy
);

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] id_q;
  logic           found;
  logic           hs;
  logic           div0_q;
  logic [N-1:0]   sel_dvd;
  logic [N-1:0]   sel_dvs;
  logic           core_done;
  logic [N-1:0]   core_q;
  logic [N-1:0]   core_r;

  // Round-robin search starting one past the most recent grant.
  always_comb begin
    found  = 1'b0;
    win_id = last;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // One-hot grant, only offered while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign hs = (state == IDLE) && found;

  // Operand mux for the current winner.
  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_dvd = req_dividend[i*N +: N];
        sel_dvs = req_divisor[i*N +: N];
      end
    end
  end

  div_core #(.N(N)) u_core (
    .clk       (pixelclk),
    .abort     (rst | flush),
    .start     (hs & ~flush & ~rst),
    .dividend  (sel_dvd),
    .divisor   (sel_dvs),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Control FSM, grant pointer and registered response.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= IDW'(NREQ - 1);
      id_q          <= '0;
      div0_q        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_div0      <= 1'b0;
      busy          <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            state  <= CALC;
            busy   <= 1'b1;
            last   <= win_id;
            id_q   <= win_id;
            div0_q <= (sel_dvs == '0);
          end
        end
        CALC: begin
          if (core_done) begin
            state         <= DONE;
            rsp_valid     <= 1'b1;
            rsp_id        <= id_q;
            rsp_quotient  <= core_q;
            rsp_remainder <= core_r;
            rsp_div0      <= div0_q;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with N=24, NREQ=3.
module tb_div_arbiter;

  localparam int unsigned N    = 24;
  localparam int unsigned NREQ = 3;
  localparam int unsigned IDW  = 2;

  logic              pixelclk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic [N-1:0]      rsp_remainder;
  logic              rsp_div0;
  logic              busy;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  div_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .pixelclk      (pixelclk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_div0      (rsp_div0),
    .busy          (busy)
  );

  always #5 pixelclk = ~pixelclk;

  always @(posedge pixelclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [N-1:0] a, input logic [N-1:0] b);
    req_dividend[r*N +: N] = a;
    req_divisor[r*N +: N]  = b;
  endtask

  // Waits for a handshake, returns winner and its cycle, then steps past the edge.
  task automatic wait_hs(output int id, output int t);
    bit found;
    found = 1'b0;
    id    = -1;
    t     = cyc;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pixelclk);
      if (|(req_valid & req_ready)) begin
        found = 1'b1;
        t     = cyc;
        for (int j = 0; j < int'(NREQ); j++) if (req_ready[j]) id = j;
      end
    end
    check("hs_seen", 32'(found), 32'd1);
    @(posedge pixelclk);
    #1;
  endtask

  // Waits for the response strobe and returns its cycle.
  task automatic wait_rsp(output int t);
    bit found;
    found = 1'b0;
    t     = cyc;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pixelclk);
      if (rsp_valid) begin
        found = 1'b1;
        t     = cyc;
      end
    end
    check("rsp_seen", 32'(found), 32'd1);
  endtask

  task automatic do_op(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    int id, t, t2;
    @(posedge pixelclk);
    #1;
    set_op(r, a, b);
    req_valid = 3'(1 << r);
    wait_hs(id, t);
    check("op_grant", 32'(id), 32'(r));
    req_valid = '0;
    check("op_busy", 32'(busy), 32'd1);
    wait_rsp(t2);
    check("op_latency", 32'(t2 - t), 32'd25);
    check("op_id", 32'(rsp_id), 32'(r));
    check("op_quotient", 32'(rsp_quotient), 32'(eq));
    check("op_remainder", 32'(rsp_remainder), 32'(er));
    check("op_div0", 32'(rsp_div0), 32'(ez));
    @(negedge pixelclk);
    check("op_strobe_one_cycle", 32'(rsp_valid), 32'd0);
    check("op_hold_quotient", 32'(rsp_quotient), 32'(eq));
  endtask

  initial begin
    int id, id2, t, t2, t3, tp, u;
    int fq[3];
    int fr[3];
    fq = '{6, 7, 2};
    fr = '{2, 1, 1};

    rst          = 1'b1;
    flush        = 1'b0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (2) @(posedge pixelclk);
    #1 rst = 1'b0;
    @(negedge pixelclk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_quotient", 32'(rsp_quotient), 32'd0);
    check("rst_remainder", 32'(rsp_remainder), 32'd0);
    check("rst_div0", 32'(rsp_div0), 32'd0);
    check("rst_ready_idle", 32'(req_ready), 32'd0);

    // Single operations, including divide-by-zero and extremes.
    do_op(0, 24'd100, 24'd7, 24'd14, 24'd2, 1'b0);
    do_op(1, 24'hABCDEF, 24'd0, 24'hFFFFFF, 24'hABCDEF, 1'b1);
    do_op(2, 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0);
    do_op(0, 24'd5, 24'd9, 24'd0, 24'd5, 1'b0);
    do_op(1, 24'd0, 24'd3, 24'd0, 24'd0, 1'b0);
    do_op(2, 24'd1000, 24'd10, 24'd100, 24'd0, 1'b0);

    // Fairness: all requesters valid continuously.
    @(posedge pixelclk);
    #1;
    set_op(0, 24'd20, 24'd3);
    set_op(1, 24'd50, 24'd7);
    set_op(2, 24'd9, 24'd4);
    req_valid = 3'b111;
    tp = 0;
    for (int k = 0; k < 6; k++) begin
      wait_hs(id, t);
      check($sformatf("fair%0d_grant", k), 32'(id), 32'(k % 3));
      if (k > 0) check($sformatf("fair%0d_spacing", k), 32'(t - tp), 32'd26);
      tp = t;
      wait_rsp(t2);
      check($sformatf("fair%0d_latency", k), 32'(t2 - t), 32'd25);
      check($sformatf("fair%0d_id", k), 32'(rsp_id), 32'(k % 3));
      check($sformatf("fair%0d_quotient", k), 32'(rsp_quotient), 32'(fq[k % 3]));
      check($sformatf("fair%0d_remainder", k), 32'(rsp_remainder), 32'(fr[k % 3]));
    end
    req_valid = '0;

    // Flush at CALC step 10: result dropped, queued req1 granted next cycle.
    @(posedge pixelclk);
    #1;
    set_op(0, 24'd777, 24'd5);
    set_op(1, 24'd1000, 24'd33);
    req_valid = 3'b011;
    wait_hs(id, t);
    check("flush_first_grant", 32'(id), 32'd0);
    req_valid = 3'b010;
    repeat (9) begin
      @(posedge pixelclk);
      #1;
    end
    flush = 1'b1;
    @(posedge pixelclk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_hs(id2, t2);
    check("flush_next_grant", 32'(id2), 32'd1);
    check("flush_next_cycle", 32'(t2 - t), 32'd11);
    req_valid = '0;
    wait_rsp(t3);
    check("flush_latency", 32'(t3 - t2), 32'd25);
    check("flush_rsp_id", 32'(rsp_id), 32'd1);
    check("flush_quotient", 32'(rsp_quotient), 32'd30);
    check("flush_remainder", 32'(rsp_remainder), 32'd10);

    // Handshake coinciding with flush is ignored and leaves the pointer alone.
    @(posedge pixelclk);
    #1;
    set_op(0, 24'd12, 24'd4);
    set_op(2, 24'd81, 24'd9);
    req_valid = 3'b101;
    flush     = 1'b1;
    @(negedge pixelclk);
    u = cyc;
    check("flush_hs_pick", 32'(req_ready), 32'd4);
    @(posedge pixelclk);
    #1;
    flush = 1'b0;
    check("flush_hs_ignored", 32'(busy), 32'd0);
    wait_hs(id, t);
    check("flush_hs_regrant", 32'(id), 32'd2);
    check("flush_hs_cycle", 32'(t - u), 32'd1);
    req_valid = '0;
    wait_rsp(t2);
    check("flush_hs_latency", 32'(t2 - t), 32'd25);
    check("flush_hs_id", 32'(rsp_id), 32'd2);
    check("flush_hs_quotient", 32'(rsp_quotient), 32'd9);
    check("flush_hs_remainder", 32'(rsp_remainder), 32'd0);

    // Reset mid-CALC: result dropped, pointer back to NREQ-1 so req0 wins.
    @(posedge pixelclk);
    #1;
    set_op(0, 24'd50, 24'd5);
    req_valid = 3'b001;
    wait_hs(id, t);
    check("rstmid_grant", 32'(id), 32'd0);
    req_valid = '0;
    repeat (5) begin
      @(posedge pixelclk);
      #1;
    end
    rst = 1'b1;
    @(posedge pixelclk);
    #1;
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_quotient", 32'(rsp_quotient), 32'd0);
    set_op(0, 24'd64, 24'd8);
    set_op(2, 24'd99, 24'd10);
    req_valid = 3'b101;
    wait_hs(id, t);
    check("rstmid_first_grant", 32'(id), 32'd0);
    req_valid = 3'b100;
    wait_rsp(t2);
    check("rstmid_latency", 32'(t2 - t), 32'd25);
    check("rstmid_rsp_id", 32'(rsp_id), 32'd0);
    check("rstmid_quotient0", 32'(rsp_quotient), 32'd8);
    check("rstmid_remainder0", 32'(rsp_remainder), 32'd0);
    wait_hs(id2, t3);
    check("rstmid_second_grant", 32'(id2), 32'd2);
    check("rstmid_spacing", 32'(t3 - t), 32'd26);
    req_valid = '0;
    wait_rsp(t2);
    check("rstmid_rsp_id2", 32'(rsp_id), 32'd2);
    check("rstmid_quotient2", 32'(rsp_quotient), 32'd9);
    check("rstmid_remainder2", 32'(rsp_remainder), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
